go_period_detector: RTL and testbench
=====================================

# go_period_detector

Receive-side companion to the divide-by tick generator. It watches a `go` pulse train, measures the cycle count between successive pulses, and declares lock once the interval has been stable for a configurable number of periods. It reports the recovered divide ratio, flags mismatches, and times out when the tick stream stops. It sits downstream of the tick generator in the same clock domain and is used for self-checking and for handing the recovered rate to consumer logic.

## Interface
Parameters:
- `WIDTH`, 6: width of the recovered period; measurable periods are 1 to 2^WIDTH-1.
- `MATCH_COUNT`, 3: number of consecutive equal period samples required for lock (legal range 1 to 15).

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: synchronous, active-high; overrides every other input.
- `enable`, input, 1: detector active when high.
- `go`, input, 1: tick pulse being measured; sampled each `clk`.
- `period`, output, WIDTH: recovered period in cycles while locked; 0 otherwise.
- `locked`, output, 1: high while the interval is stable.
- `period_valid`, output, 1: one-cycle pulse on entry to LOCKED.
- `mismatch`, output, 1: one-cycle pulse when a locked interval changes.
- `timeout`, output, 1: one-cycle pulse when no `go` arrives within 2^WIDTH cycles.

## Operation
- Interval counter `cnt`, WIDTH+1 bits, is loaded with 1 on the cycle after a sampled `go` and increments by 1 each cycle otherwise. If `go` arrives when `cnt` = k, the sample is k. With a generator divide ratio of N, the sample is N.
- State register candidate `cand`, WIDTH bits.
- State register `match`, 4 bits.
- States:
  - IDLE: `enable` = 0.
  - WAIT_FIRST: waiting for the first `go`, which starts timing.
  - MEASURE: collecting samples.
  - LOCKED: interval is stable.
- Transitions and actions:
  - Any state with `enable` = 0 → IDLE. Clear `locked`, `period`, `match`, `cnt`.
  - IDLE with `enable` = 1 → WAIT_FIRST. A `go` in this cycle is ignored.
  - WAIT_FIRST with `go` → MEASURE, `cnt`←1.
  - MEASURE with `go`:
    - If `match` = 0 or sample = `cand`: `match`++ and `cand`←sample.
    - Otherwise: `cand`←sample and `match`←1.
    - If the new `match` = MATCH_COUNT → LOCKED: `period`←`cand`, `locked`←1, `period_valid` pulse.
  - LOCKED with `go`:
    - Sample = `period`: stay in LOCKED.
    - Sample differs: `mismatch` pulse, `locked`←0, `period`←0 → MEASURE with `cand`←sample and `match`←1.
  - MEASURE or LOCKED with `cnt` = 2^WIDTH:
    - `timeout` pulse, `locked`←0, `period`←0, `match`←0.
    - If `go` is also high in this cycle, it is treated as a new first pulse: → MEASURE, `cnt`←1.
    - Otherwise → WAIT_FIRST.
    - Timeout takes priority over the sample because a period of 2^WIDTH is not representable.
- `cnt` never wraps. It holds at 2^WIDTH only for the timeout cycle.
- `mismatch`, `timeout` and `period_valid` are mutually exclusive.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `period` = 0, `locked` = 0, `period_valid` = 0, `mismatch` = 0, `timeout` = 0, `cnt` = 0, `match` = 0, `cand` = 0.
- Outputs update on the edge that samples the triggering `go` and are visible in the following cycle.
- Lock latency: MATCH_COUNT+1 pulses of `go` after WAIT_FIRST is entered. With the default parameters and N = 5, `locked` rises 1 cycle after the 4th pulse, which is 15 cycles after the 1st pulse.
- Timeout fires 2^WIDTH cycles after the last sampled `go`.
- Reset mid-operation returns to IDLE on the next edge. No partial state survives.
- `enable` dropping mid-measurement discards all history. Re-enabling requires a full relock.

## Structure
- Shared package `go_tick_pkg`:
  - State enum `det_state_t` with IDLE, WAIT_FIRST, MEASURE, LOCKED.
  - Default `WIDTH` constant of 6, shared with the tick generator's divide-ratio width.
  - Default `MATCH_COUNT`.
- Sub-module `go_interval_counter`:
  - WIDTH+1-bit counter with load-on-`go` and terminal flag at `cnt` = 2^WIDTH.
  - Instantiated once.
- FSM, candidate/match tracking and output registers live in the top module.

## Test plan
- Steady rate: `go` every 5 cycles after `enable`↑ → `period_valid` pulse and `locked` = 1 one cycle after the 4th pulse; `period` = 5; no `mismatch` or `timeout`.
- Continuous ticks: `go` held high → lock with `period` = 1 after 4 cycles in MEASURE/WAIT_FIRST. Maximum rate: `go` every 63 cycles → `period` = 63 and no timeout.
- Rate change: locked at 5, then switch to every 7 cycles → `mismatch` pulse one cycle after the first 7-cycle sample, `locked` = 0, `period` = 0; relock to 7 after 2 more 7-cycle samples.
- Stall: locked at 9, then `go` stops → `timeout` pulse exactly 64 cycles after the last `go`, state WAIT_FIRST, `locked` = 0. Also drive `go` coincident with `cnt` = 64 → `timeout` plus restart, followed by normal relock.
- Jitter before lock: samples 5, 6, 5, 5, 5 → lock only after the last three equal samples, `period` = 5.
- Reset and enable mid-operation: assert `reset` for 1 cycle while `match` = 2 → all outputs at reset values next cycle, and lock requires 4 fresh pulses. Drop `enable` while locked → `locked` and `period` cleared next cycle. A `go` in the cycle `enable` rises is ignored.

Source files
------------

// File: rtl/go_tick_pkg.sv
// -----------------------------------------------------------------------------
// go_tick_pkg
// Shared definitions for the go tick generator and its receive-side period
// detector: the detector state encoding, the default divide-ratio width and
// the default number of matching samples required for lock.
// -----------------------------------------------------------------------------
package go_tick_pkg;

   // Detector states.
   //   IDLE       : detector disabled
   //   WAIT_FIRST : enabled, waiting for the pulse that starts timing
   //   MEASURE    : collecting interval samples toward lock
   //   LOCKED     : interval has been stable for MATCH_COUNT samples
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      MEASURE    = 2'd2,
      LOCKED     = 2'd3
   } det_state_t;

   // Divide-ratio width shared with the tick generator.
   localparam int GO_WIDTH = 6;

   // Consecutive equal samples needed before declaring lock (1..15).
   localparam int GO_MATCH_COUNT = 3;

   // The match counter is 4 bits; saturate rather than wrap so a long run of
   // equal samples can never fall back below the lock threshold.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/go_interval_counter.sv
// -----------------------------------------------------------------------------
// go_interval_counter
// WIDTH+1-bit interval counter for the go period detector. It is reloaded
// with 1 on the cycle after a sampled go, so the value seen when the next go
// arrives is exactly the pulse-to-pulse interval. The extra top bit lets the
// counter reach 2^WIDTH, which is reported as the terminal (timeout) flag.
//
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears the count
//   clear    : force the count to 0 (detector idle / waiting / timed out)
//   load     : a go was sampled this cycle; count becomes 1
//   inc      : advance the count by one (held once terminal is reached)
//   sample   : low WIDTH bits of the count, i.e. the interval sample
//   terminal : count equals 2^WIDTH
// -----------------------------------------------------------------------------
module go_interval_counter
   import go_tick_pkg::*;
#(
   parameter int WIDTH = GO_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             inc,
   output logic [WIDTH-1:0] sample,
   output logic             terminal
);

   localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0] CNT_TERM = {1'b1, {WIDTH{1'b0}}};

   logic [WIDTH:0] cnt;

   // Clear has priority over load so a disabled detector never starts timing;
   // load has priority over increment so a go at the terminal count restarts.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_ONE;
      end else if (inc && (cnt != CNT_TERM)) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign sample   = cnt[WIDTH-1:0];
   assign terminal = (cnt == CNT_TERM);

endmodule

// File: rtl/go_period_detector.sv
// -----------------------------------------------------------------------------
// go_period_detector
// Receive-side companion of the divide-by tick generator. Measures the cycle
// count between successive go pulses, declares lock once MATCH_COUNT
// consecutive samples agree, reports the recovered period, flags a change of
// a locked interval and times out when no go arrives within 2^WIDTH cycles.
//
// Parameters:
//   WIDTH       : period width; measurable periods are 1 .. 2^WIDTH-1
//   MATCH_COUNT : consecutive equal samples required for lock (1..15)
//
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous active-high reset, overrides every input
//   enable       : detector active when high; low discards all history
//   go           : tick pulse being measured, sampled every clk
//   period       : recovered period while locked, 0 otherwise
//   locked       : high while the interval is stable
//   period_valid : one-cycle pulse on entry to LOCKED
//   mismatch     : one-cycle pulse when a locked interval changes
//   timeout      : one-cycle pulse when no go arrives within 2^WIDTH cycles
//
// All outputs are registered; they reflect the go sampled on the previous
// edge.
// -----------------------------------------------------------------------------
module go_period_detector
   import go_tick_pkg::*;
#(
   parameter int WIDTH       = GO_WIDTH,
   parameter int MATCH_COUNT = GO_MATCH_COUNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             go,
   output logic [WIDTH-1:0] period,
   output logic             locked,
   output logic             period_valid,
   output logic             mismatch,
   output logic             timeout
);

   localparam logic [3:0] MATCH_TGT = 4'(MATCH_COUNT);

   det_state_t       state, state_next;
   logic [WIDTH-1:0] cand, cand_next;
   logic [3:0]       match, match_next;
   logic [3:0]       match_new;
   logic [WIDTH-1:0] period_next;
   logic             locked_next;
   logic             period_valid_next;
   logic             mismatch_next;
   logic             timeout_next;

   logic             cnt_clear;
   logic             cnt_load;
   logic             cnt_inc;
   logic [WIDTH-1:0] sample;
   logic             terminal;

   go_interval_counter #(
      .WIDTH (WIDTH)
   ) u_interval_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .inc      (cnt_inc),
      .sample   (sample),
      .terminal (terminal)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cand         <= '0;
         match        <= '0;
         period       <= '0;
         locked       <= 1'b0;
         period_valid <= 1'b0;
         mismatch     <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_next;
         cand         <= cand_next;
         match        <= match_next;
         period       <= period_next;
         locked       <= locked_next;
         period_valid <= period_valid_next;
         mismatch     <= mismatch_next;
         timeout      <= timeout_next;
      end
   end

   // Next-state, tracking and output decode
   always_comb begin
      state_next        = state;
      cand_next         = cand;
      match_next        = match;
      match_new         = match;
      period_next       = period;
      locked_next       = locked;
      period_valid_next = 1'b0;
      mismatch_next     = 1'b0;
      timeout_next      = 1'b0;
      cnt_clear         = 1'b0;
      cnt_load          = 1'b0;
      cnt_inc           = 1'b0;

      if (!enable) begin
         // Disabling throws away everything learned so far.
         state_next  = IDLE;
         locked_next = 1'b0;
         period_next = '0;
         match_next  = '0;
         cnt_clear   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // A go coincident with enable rising is deliberately ignored.
               state_next = WAIT_FIRST;
               cnt_clear  = 1'b1;
            end

            WAIT_FIRST: begin
               if (go) begin
                  state_next = MEASURE;
                  cnt_load   = 1'b1;
               end else begin
                  cnt_clear  = 1'b1;
               end
            end

            MEASURE, LOCKED: begin
               cnt_inc = 1'b1;
               if (terminal) begin
                  // A 2^WIDTH interval is not representable, so timeout wins
                  // over any coincident go; that go restarts timing instead.
                  timeout_next = 1'b1;
                  locked_next  = 1'b0;
                  period_next  = '0;
                  match_next   = '0;
                  if (go) begin
                     state_next = MEASURE;
                     cnt_load   = 1'b1;
                  end else begin
                     state_next = WAIT_FIRST;
                     cnt_clear  = 1'b1;
                  end
               end else if (go) begin
                  cnt_load = 1'b1;
                  if (state == MEASURE) begin
                     if ((match == 4'd0) || (sample == cand)) begin
                        match_new = sat_inc4(match);
                     end else begin
                        match_new = 4'd1;
                     end
                     cand_next  = sample;
                     match_next = match_new;
                     if (match_new >= MATCH_TGT) begin
                        state_next        = LOCKED;
                        period_next       = sample;
                        locked_next       = 1'b1;
                        period_valid_next = 1'b1;
                     end
                  end else if (sample != period) begin
                     // The changed sample becomes the first of a new run.
                     state_next    = MEASURE;
                     mismatch_next = 1'b1;
                     locked_next   = 1'b0;
                     period_next   = '0;
                     cand_next     = sample;
                     match_next    = 4'd1;
                  end
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_go_period_detector.sv
// -----------------------------------------------------------------------------
// tb_go_period_detector
// Directed bench for go_period_detector (WIDTH=6, MATCH_COUNT=3). A reference
// model tracks go arrival times and the run of equal intervals; a compare
// process checks every output on every cycle, and literal checks at key
// points pin the expected behaviour of the scenarios.
// -----------------------------------------------------------------------------
module tb_go_period_detector;

   localparam int W     = 6;
   localparam int MC    = 3;
   localparam int LIMIT = 1 << W;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         go;
   logic [W-1:0] period;
   logic         locked;
   logic         period_valid;
   logic         mismatch;
   logic         timeout;

   int vectors = 0;
   int fails   = 0;

   go_period_detector #(
      .WIDTH       (W),
      .MATCH_COUNT (MC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .go           (go),
      .period       (period),
      .locked       (locked),
      .period_valid (period_valid),
      .mismatch     (mismatch),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 = off, 1 = waiting for first go, 2 = timing.
   int cyc     = 0;
   int phase   = 0;
   int last_go = 0;
   int elapsed;
   int hist[$];
   bit m_locked = 1'b0;
   int m_period = 0;
   bit m_pv     = 1'b0;
   bit m_mm     = 1'b0;
   bit m_to     = 1'b0;

   always @(posedge clk) begin
      cyc++;
      m_pv = 1'b0;
      m_mm = 1'b0;
      m_to = 1'b0;
      if (reset || !enable) begin
         phase    = 0;
         m_locked = 1'b0;
         m_period = 0;
         hist.delete();
      end else if (phase == 0) begin
         phase = 1;
      end else if (phase == 1) begin
         if (go) begin
            phase   = 2;
            last_go = cyc;
         end
      end else begin
         elapsed = cyc - last_go;
         if (elapsed >= LIMIT) begin
            m_to     = 1'b1;
            m_locked = 1'b0;
            m_period = 0;
            hist.delete();
            if (go) last_go = cyc;
            else    phase   = 1;
         end else if (go) begin
            last_go = cyc;
            if (m_locked) begin
               if (elapsed != m_period) begin
                  m_mm     = 1'b1;
                  m_locked = 1'b0;
                  m_period = 0;
                  hist.delete();
                  hist.push_back(elapsed);
               end
            end else begin
               if (hist.size() > 0 && hist[hist.size()-1] != elapsed) hist.delete();
               hist.push_back(elapsed);
               if (hist.size() >= MC) begin
                  m_locked = 1'b1;
                  m_period = elapsed;
                  m_pv     = 1'b1;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (cyc > 0) begin
         vectors++;
         if (period !== 6'(m_period) || locked !== m_locked || period_valid !== m_pv ||
             mismatch !== m_mm || timeout !== m_to) begin
            fails++;
            $display("FAIL model_cmp cyc=%0d got p=%0d l=%b v=%b m=%b t=%b want p=%0d l=%b v=%b m=%b t=%b",
                     cyc, period, locked, period_valid, mismatch, timeout,
                     m_period, m_locked, m_pv, m_mm, m_to);
         end
         vectors++;
         if ($countones({period_valid, mismatch, timeout}) > 1) begin
            fails++;
            $display("FAIL pulse_exclusive cyc=%0d got v=%b m=%b t=%b want at most one high",
                     cyc, period_valid, mismatch, timeout);
         end
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle go pulse; returns just after the edge that sampled it.
   task automatic pulse();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   // Go pulse n cycles after the previous one.
   task automatic gap_pulse(input int n);
      go = 1'b0;
      repeat (n - 1) @(negedge clk);
      pulse();
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      go     = 1'b0;
      step(3);
      reset = 1'b0;
      lit("reset_period", int'(period), 0);
      lit("reset_locked", int'(locked), 0);
      lit("reset_pulses", int'({period_valid, mismatch, timeout}), 0);

      // Steady rate 5; the go coincident with enable rising is ignored.
      enable = 1'b1;
      go     = 1'b1;
      step(1);
      go = 1'b0;
      for (int i = 0; i < 3; i++) gap_pulse(5);
      lit("ignore_go_on_enable", int'(locked), 0);
      gap_pulse(5);
      lit("lock5_valid", int'(period_valid), 1);
      lit("lock5_locked", int'(locked), 1);
      lit("lock5_period", int'(period), 5);
      gap_pulse(5);
      gap_pulse(5);
      lit("stay5_locked", int'(locked), 1);

      // Rate change 5 -> 7.
      gap_pulse(7);
      lit("chg7_mismatch", int'(mismatch), 1);
      lit("chg7_locked", int'(locked), 0);
      lit("chg7_period", int'(period), 0);
      gap_pulse(7);
      lit("chg7_not_yet", int'(locked), 0);
      gap_pulse(7);
      lit("relock7_valid", int'(period_valid), 1);
      lit("relock7_period", int'(period), 7);

      // Lock at 9 then stall.
      for (int i = 0; i < 3; i++) gap_pulse(9);
      lit("lock9_period", int'(period), 9);
      step(63);
      lit("stall_before", int'(timeout), 0);
      step(1);
      lit("stall_timeout", int'(timeout), 1);
      lit("stall_locked", int'(locked), 0);
      lit("stall_period", int'(period), 0);

      // Restart from WAIT_FIRST, then go coincident with the terminal count.
      pulse();
      for (int i = 0; i < 3; i++) gap_pulse(9);
      lit("relock9_period", int'(period), 9);
      gap_pulse(LIMIT);
      lit("coinc_timeout", int'(timeout), 1);
      lit("coinc_mismatch", int'(mismatch), 0);
      gap_pulse(9);
      gap_pulse(9);
      lit("coinc_not_yet", int'(locked), 0);
      gap_pulse(9);
      lit("coinc_relock", int'(period), 9);

      // Maximum period 63.
      gap_pulse(63);
      lit("max_mismatch", int'(mismatch), 1);
      gap_pulse(63);
      gap_pulse(63);
      lit("max_period", int'(period), 63);
      lit("max_no_timeout", int'(timeout), 0);

      // Enable drop while locked.
      enable = 1'b0;
      step(1);
      lit("disable_locked", int'(locked), 0);
      lit("disable_period", int'(period), 0);

      // Continuous go.
      enable = 1'b1;
      go     = 1'b1;
      step(4);
      lit("cont_not_yet", int'(locked), 0);
      step(1);
      lit("cont_locked", int'(locked), 1);
      lit("cont_period", int'(period), 1);
      step(3);
      lit("cont_hold", int'(period), 1);
      go = 1'b0;

      // Jitter before lock: 5, 6, 5, 5, 5.
      enable = 1'b0;
      step(1);
      enable = 1'b1;
      step(1);
      pulse();
      gap_pulse(5);
      gap_pulse(6);
      gap_pulse(5);
      gap_pulse(5);
      lit("jitter_not_yet", int'(locked), 0);
      gap_pulse(5);
      lit("jitter_lock", int'(locked), 1);
      lit("jitter_period", int'(period), 5);

      // Reset with match = 2.
      enable = 1'b0;
      step(1);
      enable = 1'b1;
      step(1);
      pulse();
      gap_pulse(5);
      gap_pulse(5);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      lit("midrst_period", int'(period), 0);
      lit("midrst_locked", int'(locked), 0);
      lit("midrst_pulses", int'({period_valid, mismatch, timeout}), 0);
      step(1);
      pulse();
      gap_pulse(5);
      gap_pulse(5);
      lit("midrst_fresh", int'(locked), 0);
      gap_pulse(5);
      lit("midrst_relock", int'(locked), 1);

      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
